// File: rtl/mdio_controller.sv
// Clause-22 MDIO station-management master: serialises a 32-bit frame word on
// MDC/MDIO_OUT/MDIO_OE, optionally preceded by PRE_LEN preamble ones, and
// returns the 16-bit read value with a one-cycle DATA_RDY strobe.
// Latency: accept edge to DONE = (PRE_LEN+32)*2*MDC_HALF CLK cycles, BUSY drops one cycle later.
// Backpressure: MDIO_START is only honoured in IDLE; requests while BUSY are dropped.
//
// Ports:
//   CLK, RESET           system clock, asynchronous active-high reset
//   MDIO_START, T_DATA   request strobe and frame word (ST,OP,PHYAD,REGAD,TA,DATA)
//   MDIO_IN              serial data from the peripheral
//   MDC, MDIO_OUT, MDIO_OE  management clock, serial data out, output enable
//   RD_DATA, DATA_RDY    last read value and its one-cycle update pulse
//   BUSY                 high from request acceptance until return to IDLE
module mdio_controller #(
    parameter int MDC_HALF = 2,
    parameter int PRE_LEN  = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        BUSY
);

    localparam int PW = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
    localparam logic [PW-1:0] PH_TC  = PW'(MDC_HALF - 1);
    localparam logic [5:0]    PRE_TC = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   phase, phase_nxt;
    logic [5:0]      bit_cnt, bit_cnt_nxt;
    logic [31:0]     shreg, shreg_nxt;
    logic [15:0]     cap, cap_nxt;
    logic [15:0]     rd_data_nxt;
    logic            is_read, is_read_nxt;
    logic            mdc_nxt, out_nxt, oe_nxt, rdy_nxt, busy_nxt;
    logic            tick, rise, fall;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            cap      <= '0;
            is_read  <= 1'b0;
            MDC      <= 1'b0;
            MDIO_OUT <= 1'b0;
            MDIO_OE  <= 1'b0;
            RD_DATA  <= 16'h0000;
            DATA_RDY <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            cap      <= cap_nxt;
            is_read  <= is_read_nxt;
            MDC      <= mdc_nxt;
            MDIO_OUT <= out_nxt;
            MDIO_OE  <= oe_nxt;
            RD_DATA  <= rd_data_nxt;
            DATA_RDY <= rdy_nxt;
            BUSY     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        cap_nxt     = cap;
        is_read_nxt = is_read;
        mdc_nxt     = MDC;
        out_nxt     = MDIO_OUT;
        oe_nxt      = MDIO_OE;
        rd_data_nxt = RD_DATA;
        rdy_nxt     = 1'b0;
        busy_nxt    = BUSY;

        // The divider only runs while a frame is on the wire. A terminal
        // count with MDC low is a rising event (peripheral samples), with MDC
        // high it is a falling event (we move to the next bit).
        tick = ((state == S_PREAMBLE) || (state == S_SHIFT)) && (phase == PH_TC);
        rise = tick && !MDC;
        fall = tick && MDC;

        if ((state == S_PREAMBLE) || (state == S_SHIFT)) begin
            phase_nxt = tick ? '0 : phase + PW'(1);
            mdc_nxt   = tick ? ~MDC : MDC;
        end

        case (state)
            S_IDLE: begin
                mdc_nxt = 1'b0;
                oe_nxt  = 1'b0;
                if (MDIO_START) begin
                    shreg_nxt   = T_DATA;
                    is_read_nxt = (T_DATA[29:28] == 2'b10);
                    busy_nxt    = 1'b1;
                    oe_nxt      = 1'b1;
                    phase_nxt   = '0;
                    bit_cnt_nxt = '0;
                    cap_nxt     = '0;
                    if (PRE_LEN > 0) begin
                        out_nxt   = 1'b1;
                        state_nxt = S_PREAMBLE;
                    end else begin
                        out_nxt   = T_DATA[31];
                        state_nxt = S_SHIFT;
                    end
                end
            end

            S_PREAMBLE: begin
                if (fall) begin
                    if (bit_cnt == PRE_TC) begin
                        out_nxt     = shreg[31];
                        bit_cnt_nxt = '0;
                        state_nxt   = S_SHIFT;
                    end else begin
                        out_nxt     = 1'b1;
                        bit_cnt_nxt = bit_cnt + 6'd1;
                    end
                end
            end

            S_SHIFT: begin
                // Only the data field of a read is captured; TA is never
                // sampled so an undriven bus there cannot pollute RD_DATA.
                if (rise && is_read && (bit_cnt >= 6'd16)) begin
                    cap_nxt = {cap[14:0], MDIO_IN};
                end
                if (fall) begin
                    if (bit_cnt == 6'd31) begin
                        state_nxt = S_DONE;
                        mdc_nxt   = 1'b0;
                        oe_nxt    = 1'b0;
                        out_nxt   = 1'b0;
                        phase_nxt = '0;
                        if (is_read) begin
                            rd_data_nxt = cap;
                            rdy_nxt     = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 6'd1;
                        shreg_nxt   = {shreg[30:0], 1'b0};
                        // Falling event that starts bit 14 (TA) hands the
                        // bus to the peripheral for the rest of a read.
                        if (is_read && (bit_cnt >= 6'd13)) begin
                            oe_nxt  = 1'b0;
                            out_nxt = 1'b0;
                        end else begin
                            out_nxt = shreg[30];
                        end
                    end
                end
            end

            S_DONE: begin
                state_nxt   = S_IDLE;
                busy_nxt    = 1'b0;
                bit_cnt_nxt = '0;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdio_controller.sv
`timescale 1ns/1ps
module tb_mdio_controller;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET;
    logic        start_a, start_b;
    logic [31:0] tdata_a, tdata_b;
    logic        mdio_in_a = 1'b0;
    logic        mdio_in_b;
    logic        mdc_a, out_a, oe_a, rdy_a, busy_a;
    logic        mdc_b, out_b, oe_b, rdy_b, busy_b;
    logic [15:0] rd_a, rd_b;

    mdio_controller #(.MDC_HALF(2), .PRE_LEN(0)) u_dut (
        .CLK(CLK), .RESET(RESET), .MDIO_START(start_a), .T_DATA(tdata_a),
        .MDIO_IN(mdio_in_a), .MDC(mdc_a), .MDIO_OUT(out_a), .MDIO_OE(oe_a),
        .RD_DATA(rd_a), .DATA_RDY(rdy_a), .BUSY(busy_a)
    );

    mdio_controller #(.MDC_HALF(2), .PRE_LEN(32)) u_dut_pre (
        .CLK(CLK), .RESET(RESET), .MDIO_START(start_b), .T_DATA(tdata_b),
        .MDIO_IN(mdio_in_b), .MDC(mdc_b), .MDIO_OUT(out_b), .MDIO_OE(oe_b),
        .RD_DATA(rd_b), .DATA_RDY(rdy_b), .BUSY(busy_b)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed { logic out; logic oe; } bit_t;
    typedef struct { logic [15:0] d; int c; } rd_t;

    bit_t exp_a[$];
    bit_t exp_b[$];
    rd_t  exp_rd[$];

    // Peripheral model state for the PRE_LEN=0 instance.
    logic [15:0] per_val = 16'h0000;
    bit          per_xta = 1'b0;
    int          rise_cnt = 0;
    logic        prev_a = 1'b0, prev_b = 1'b0;
    bit_t        ea, eb;
    rd_t         er;
    int          t0;

    // Monitor: compares each MDC-rise bit and every DATA_RDY against the queues.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (mdc_a && !prev_a) begin
                if (exp_a.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL a_extra_bit: got MDC rise %0d, expected none (cycle %0d)", rise_cnt, cyc);
                end else begin
                    ea = exp_a.pop_front();
                    check("a_mdio_out", {31'd0, out_a}, {31'd0, ea.out});
                    check("a_mdio_oe",  {31'd0, oe_a},  {31'd0, ea.oe});
                end
                rise_cnt++;
            end
            if (!mdc_a && prev_a) begin
                if (rise_cnt >= 16 && rise_cnt <= 31)
                    mdio_in_a = per_val[31 - rise_cnt];
                else if (per_xta && rise_cnt >= 14 && rise_cnt <= 15)
                    mdio_in_a = 1'bx;
                else
                    mdio_in_a = 1'b0;
            end
            if (!busy_a) rise_cnt = 0;
            if (rdy_a) begin
                if (exp_rd.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL a_extra_rdy: got DATA_RDY with RD_DATA %h, expected none (cycle %0d)", rd_a, cyc);
                end else begin
                    er = exp_rd.pop_front();
                    check("rd_data",  {16'd0, rd_a}, {16'd0, er.d});
                    check("rdy_cycle", cyc, er.c);
                end
            end
            if (mdc_b && !prev_b) begin
                if (exp_b.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL b_extra_bit: got MDC rise, expected none (cycle %0d)", cyc);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_mdio_out", {31'd0, out_b}, {31'd0, eb.out});
                    check("b_mdio_oe",  {31'd0, oe_b},  {31'd0, eb.oe});
                end
            end
            if (rdy_b) begin
                n_vec++; n_fail++;
                $display("FAIL b_rdy: got DATA_RDY on a write, expected 0 (cycle %0d)", cyc);
            end
        end
        prev_a = mdc_a;
        prev_b = mdc_b;
    end

    task automatic launch_a(input logic [31:0] d);
        @(negedge CLK);
        start_a = 1'b1;
        tdata_a = d;
        @(negedge CLK);
        start_a = 1'b0;
        t0 = cyc;
        check("busy_accept", {31'd0, busy_a}, 32'd1);
    endtask

    task automatic push_write(input logic [31:0] stream);
        for (int i = 0; i < 32; i++) exp_a.push_back('{stream[31 - i], 1'b1});
    endtask

    task automatic push_read(input logic [31:0] d, input logic [15:0] v, input int ts);
        for (int i = 0; i < 32; i++)
            exp_a.push_back((i < 14) ? '{d[31 - i], 1'b1} : '{1'b0, 1'b0});
        exp_rd.push_back('{v, ts + 128});
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while (busy_a && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check(name, cyc - t0, 32'd129);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mdc"},  {31'd0, mdc_a},  32'd0);
        check({tag, "_out"},  {31'd0, out_a},  32'd0);
        check({tag, "_oe"},   {31'd0, oe_a},   32'd0);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_rdy"},  {31'd0, rdy_a},  32'd0);
        check({tag, "_rd"},   {16'd0, rd_a},   32'd0);
    endtask

    logic [31:0] misc_writes [2];
    int busy_seen;

    initial begin
        misc_writes[0] = 32'h4123_8001;  // OP=00
        misc_writes[1] = 32'h7A5A_5A5A;  // OP=11
        RESET = 1'b1; start_a = 1'b0; start_b = 1'b0;
        tdata_a = '0; tdata_b = '0; mdio_in_b = 1'b0;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RESET = 1'b0;

        // Plain write, hand-expanded bit stream.
        launch_a(32'h50C2_ABCD);
        push_write(32'b0101_00001_10000_10_1010101111001101);
        wait_idle_a("write_busy_fall");
        check("write_drained", exp_a.size(), 32'd0);

        // Read returning 16'h1234.
        per_val = 16'h1234; per_xta = 1'b0;
        launch_a(32'h60C0_0000);
        push_read(32'h60C0_0000, 16'h1234, t0);
        wait_idle_a("read_busy_fall");
        check("read_rd_hold", {16'd0, rd_a}, 32'h0000_1234);
        check("read_drained", exp_rd.size(), 32'd0);

        // Read with X on the bus during TA.
        per_val = 16'hFFFF; per_xta = 1'b1;
        launch_a(32'h6842_0000);
        push_read(32'h6842_0000, 16'hFFFF, t0);
        wait_idle_a("readx_busy_fall");
        check("readx_no_x", {31'd0, $isunknown(rd_a)}, 32'd0);
        per_xta = 1'b0;

        // OP=00 and OP=11 are shifted out as writes.
        for (int k = 0; k < 2; k++) begin
            launch_a(misc_writes[k]);
            push_write(misc_writes[k]);
            wait_idle_a("opwrite_busy_fall");
            check("opwrite_rd_hold", {16'd0, rd_a}, 32'h0000_FFFF);
        end

        // START pulse mid-frame is ignored.
        launch_a(32'h50C2_ABCD);
        push_write(32'h50C2_ABCD);
        while (cyc < t0 + 20) @(negedge CLK);
        start_a = 1'b1; tdata_a = 32'hFFFF_FFFF;
        @(negedge CLK);
        start_a = 1'b0;
        wait_idle_a("ignore_busy_fall");
        busy_seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (busy_a) busy_seen++;
        end
        check("ignore_no_second_frame", busy_seen, 32'd0);
        check("ignore_drained", exp_a.size(), 32'd0);

        // START held high: back-to-back frames with one IDLE cycle.
        @(negedge CLK);
        start_a = 1'b1; tdata_a = 32'h5A5A_0F0F;
        @(negedge CLK);
        t0 = cyc;
        push_write(32'h5A5A_0F0F);
        push_write(32'h5A5A_0F0F);
        wait_idle_a("b2b_first_fall");
        @(negedge CLK);
        check("b2b_restart", {31'd0, busy_a}, 32'd1);
        start_a = 1'b0;
        t0 = cyc;
        wait_idle_a("b2b_second_fall");
        check("b2b_drained", exp_a.size(), 32'd0);

        // Reset mid-read, then a clean read.
        per_val = 16'hBEEF;
        launch_a(32'h6084_0000);
        push_read(32'h6084_0000, 16'hBEEF, t0);
        while (cyc < t0 + 60) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_a.delete();
        exp_rd.delete();
        @(negedge CLK);
        RESET = 1'b0;
        per_val = 16'hA5C3;
        launch_a(32'h60C0_0000);
        push_read(32'h60C0_0000, 16'hA5C3, t0);
        wait_idle_a("postreset_busy_fall");
        check("postreset_rd", {16'd0, rd_a}, 32'h0000_A5C3);

        // 32-bit preamble instance.
        @(negedge CLK);
        start_b = 1'b1; tdata_b = 32'h50C2_ABCD;
        @(negedge CLK);
        start_b = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 32; i++) exp_b.push_back('{1'b1, 1'b1});
        for (int i = 0; i < 32; i++) exp_b.push_back('{tdata_b[31 - i], 1'b1});
        begin
            int n = 0;
            while (busy_b && n < 600) begin
                @(negedge CLK);
                n++;
            end
        end
        check("pre_busy_fall", cyc - t0, 32'd257);
        check("pre_drained", exp_b.size(), 32'd0);

        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
